// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU among
// NUM_REQ valid/ready requesters and returns each result tagged with its owner.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_op1,
  input  logic [NUM_REQ*32-1:0] req_op2,
  input  logic [NUM_REQ*4-1:0]  req_sel,
  output logic [31:0]           alu_op1,
  output logic [31:0]           alu_op2,
  output logic [3:0]            alu_sel,
  input  logic [31:0]           alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_cur_id;
  logic [31:0]       r_alu_op1;
  logic [31:0]       r_alu_op2;
  logic [3:0]        r_alu_sel;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_busy;

  logic [NUM_REQ-1:0] w_grant_vec;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_scan_idx;
  logic               w_grant_any;
  logic               w_take;

  // Both operands are below NUM_REQ, so one conditional subtract keeps ids in range
  // even when NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= $unsigned(NUM_REQ)) begin
      sum = sum - $unsigned(NUM_REQ);
    end
    return sum[ID_W-1:0];
  endfunction

  // Round-robin scan from r_rr_ptr; first valid requester wins.
  always_comb begin
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    w_scan_idx  = '0;
    w_take      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx  = wrap_add(r_rr_ptr, k);
      w_take      = ~w_grant_any & req_valid[w_scan_idx];
      w_grant_idx = w_take ? w_scan_idx : w_grant_idx;
      w_grant_any = w_grant_any | w_take;
    end
    w_grant_vec = w_grant_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx)
                              : {NUM_REQ{1'b0}};
  end

  // Grants are only offered from IDLE and never while reset is held.
  assign req_ready = ((r_state == S_IDLE) && !rst) ? w_grant_vec : {NUM_REQ{1'b0}};

  // Control FSM with registered ALU operands and response channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cur_id    <= '0;
      r_alu_op1   <= 32'd0;
      r_alu_op2   <= 32'd0;
      r_alu_sel   <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_alu_op1 <= req_op1[32*w_grant_idx +: 32];
            r_alu_op2 <= req_op2[32*w_grant_idx +: 32];
            r_alu_sel <= req_sel[4*w_grant_idx +: 4];
            r_cur_id  <= w_grant_idx;
            r_rr_ptr  <= wrap_add(w_grant_idx, 32'd1);
            r_state   <= S_EXEC;
            r_busy    <= 1'b1;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_id    <= r_cur_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Returning to IDLE here means the next grant is at least one cycle later.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op1   = r_alu_op1;
  assign alu_op2   = r_alu_op2;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a 4-requester instance with a behavioural ALU and a
// response scoreboard, plus a 3-requester instance for pointer wrap.
module tb_alu_rr_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_XOR:  return a ^ b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // 4-requester instance
  logic [3:0]   valid4 = 4'b0;
  logic [3:0]   ready4;
  logic [31:0]  op1_4 [4];
  logic [31:0]  op2_4 [4];
  logic [3:0]   sel_4 [4];
  logic [127:0] bus_op1_4, bus_op2_4;
  logic [15:0]  bus_sel_4;
  logic [31:0]  alu_op1_4, alu_op2_4, alu_out_4, rsp_data4;
  logic [3:0]   alu_sel_4;
  logic         rsp_valid4, busy4;
  logic         rsp_ready4 = 1'b1;
  logic [1:0]   rsp_id4;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus_op1_4[32*i +: 32] = op1_4[i];
      bus_op2_4[32*i +: 32] = op2_4[i];
      bus_sel_4[4*i +: 4]   = sel_4[i];
    end
  end
  assign alu_out_4 = alu_f(alu_op1_4, alu_op2_4, alu_sel_4);

  alu_rr_arbiter #(.NUM_REQ(4), .ID_W(2)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(valid4), .req_ready(ready4),
    .req_op1(bus_op1_4), .req_op2(bus_op2_4), .req_sel(bus_sel_4),
    .alu_op1(alu_op1_4), .alu_op2(alu_op2_4), .alu_sel(alu_sel_4), .alu_out(alu_out_4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4), .rsp_id(rsp_id4),
    .busy(busy4)
  );

  // 3-requester instance
  logic [2:0]  valid3 = 3'b0;
  logic [2:0]  ready3;
  logic [31:0] op1_3 [3];
  logic [31:0] op2_3 [3];
  logic [95:0] bus_op1_3, bus_op2_3;
  logic [11:0] bus_sel_3;
  logic [31:0] alu_op1_3, alu_op2_3, alu_out_3, rsp_data3;
  logic [3:0]  alu_sel_3;
  logic        rsp_valid3, busy3;
  logic        rsp_ready3 = 1'b1;
  logic [1:0]  rsp_id3;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bus_op1_3[32*i +: 32] = op1_3[i];
      bus_op2_3[32*i +: 32] = op2_3[i];
      bus_sel_3[4*i +: 4]   = OP_ADD;
    end
  end
  assign alu_out_3 = alu_f(alu_op1_3, alu_op2_3, alu_sel_3);

  alu_rr_arbiter #(.NUM_REQ(3), .ID_W(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(valid3), .req_ready(ready3),
    .req_op1(bus_op1_3), .req_op2(bus_op2_3), .req_sel(bus_sel_3),
    .alu_op1(alu_op1_3), .alu_op2(alu_op2_3), .alu_sel(alu_sel_3), .alu_out(alu_out_3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_id(rsp_id3),
    .busy(busy3)
  );

  sb_t  sb_q[$];
  int   rsp_cyc_q[$];
  int   exp_ord [8];
  int   gcyc [8];
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%h required=0x%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] d);
    sb_t e;
    e.id   = id[1:0];
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every completed response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ($countones(ready4) > 1) begin
        bad++;
        $display("FAIL ready_onehot actual=%b required=at most one bit", ready4);
      end
      if (rsp_valid4 && rsp_ready4) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp actual id=%0d data=0x%h required=no response",
                   rsp_id4, rsp_data4);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          rsp_cyc_q.push_back(cyc);
          if (rsp_id4 !== e.id || rsp_data4 !== e.data) begin
            bad++;
            $display("FAIL rsp actual id=%0d data=0x%h required id=%0d data=0x%h",
                     rsp_id4, rsp_data4, e.id, e.data);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid3) begin
      total++;
      if (rsp_id3 >= 2'd3) begin
        bad++;
        $display("FAIL rsp_id3_range actual=%0d required=<3", rsp_id3);
      end
    end
  end

  task automatic wait_grant4(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = (ready4 != 4'b0);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL grant_timeout actual=no grant required=grant within 20 cycles");
    end
  endtask

  task automatic wait_idle4();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = !busy4;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL idle_timeout actual=busy required=idle within 20 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic grant_seq4(input int n, input bit drop);
    bit         ok;
    logic [3:0] want;
    for (int k = 0; k < n; k++) begin
      wait_grant4(ok);
      if (!ok) break;
      want = 4'b0001 << exp_ord[k];
      check("rr_grant", 32'(ready4), 32'(want));
      gcyc[k] = cyc;
      @(posedge clk);
      #1;
      if (drop) valid4[exp_ord[k]] = 1'b0;
    end
  endtask

  task automatic run_single(input vec_t v);
    logic [3:0] want;
    want = 4'b0001 << v.req;
    op1_4[v.req] = v.a;
    op2_4[v.req] = v.b;
    sel_4[v.req] = v.sel;
    valid4[v.req] = 1'b1;
    push_exp(v.req, v.exp);
    @(negedge clk);
    check("single_grant", 32'(ready4), 32'(want));
    check("single_busy_idle", 32'(busy4), 32'd0);
    @(posedge clk);
    #1;
    valid4[v.req] = 1'b0;
    @(negedge clk);
    check("exec_ready", 32'(ready4), 32'd0);
    check("exec_busy", 32'(busy4), 32'd1);
    check("exec_rsp_valid", 32'(rsp_valid4), 32'd0);
    check("exec_alu_op1", alu_op1_4, v.a);
    check("exec_alu_sel", 32'(alu_sel_4), 32'(v.sel));
    @(negedge clk);
    check("lat2_rsp_valid", 32'(rsp_valid4), 32'd1);
    check("resp_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    check("done_busy", 32'(busy4), 32'd0);
    check("done_rsp_valid", 32'(rsp_valid4), 32'd0);
    check("alu_op2_held", alu_op2_4, v.b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    vecs[0] = '{req: 2, a: 32'd5,          b: 32'd3,          sel: OP_ADD, exp: 32'd8};
    vecs[1] = '{req: 0, a: 32'd10,         b: 32'd3,          sel: OP_SUB, exp: 32'd7};
    vecs[2] = '{req: 1, a: 32'd1,          b: 32'd31,         sel: OP_SLL, exp: 32'h80000000};
    vecs[3] = '{req: 2, a: 32'hFFFFFFFF,   b: 32'd1,          sel: OP_ADD, exp: 32'd0};
    vecs[4] = '{req: 3, a: 32'hF0F0F0F0,   b: 32'h0FF00FF0,   sel: OP_XOR, exp: 32'hFF00FF00};
    for (int i = 0; i < 4; i++) begin
      op1_4[i] = 32'd10;
      op2_4[i] = 32'd20;
      sel_4[i] = OP_ADD;
    end
    for (int i = 0; i < 3; i++) begin
      op1_3[i] = 32'd0;
      op2_3[i] = 32'd0;
    end

    // Reset with every requester asking.
    valid4 = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_ready", 32'(ready4), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid4), 32'd0);
      check("rst_busy", 32'(busy4), 32'd0);
      check("rst_alu_op1", alu_op1_4, 32'd0);
      check("rst_rsp_data", rsp_data4, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(0, 32'd30);
    @(negedge clk);
    check("first_grant_req0", 32'(ready4), 32'd1);
    @(posedge clk);
    #1;
    valid4 = 4'b0;
    wait_idle4();

    // Table of single transactions.
    for (int i = 0; i < 5; i++) run_single(vecs[i]);

    // Fairness with everyone continuously valid; pointer is at 0 here.
    for (int i = 0; i < 4; i++) begin
      op1_4[i] = 32'(100 + i);
      op2_4[i] = 32'(i);
      sel_4[i] = OP_SUB;
    end
    rsp_cyc_q.delete();
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 2; exp_ord[3] = 3; exp_ord[4] = 0;
    for (int k = 0; k < 5; k++) push_exp(exp_ord[k], 32'd100);
    valid4 = 4'b1111;
    grant_seq4(5, 1'b0);
    valid4 = 4'b0;
    wait_idle4();
    for (int k = 1; k < 5; k++) check("grant_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    check("rsp_count", 32'(rsp_cyc_q.size()), 32'd5);
    for (int k = 1; k < 5 && k < rsp_cyc_q.size(); k++)
      check("rsp_spacing", 32'(rsp_cyc_q[k] - rsp_cyc_q[k-1]), 32'd3);

    // Backpressure: requester 1 wins from pointer 1, others wait behind it.
    rsp_ready4 = 1'b0;
    op1_4[1] = 32'd1;  op2_4[1] = 32'd31; sel_4[1] = OP_SLL;
    op1_4[2] = 32'd7;  op2_4[2] = 32'd8;  sel_4[2] = OP_ADD;
    op1_4[3] = 32'hFF; op2_4[3] = 32'h0F; sel_4[3] = OP_XOR;
    op1_4[0] = 32'd50; op2_4[0] = 32'd8;  sel_4[0] = OP_SUB;
    push_exp(1, 32'h80000000);
    push_exp(2, 32'd15);
    push_exp(3, 32'hF0);
    push_exp(0, 32'd42);
    valid4 = 4'b1111;
    wait_grant4(ok);
    check("bp_grant", 32'(ready4), 32'b0010);
    @(posedge clk);
    #1;
    valid4[1] = 1'b0;
    @(negedge clk);
    check("bp_exec_ready", 32'(ready4), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid4), 32'd1);
      check("bp_data", rsp_data4, 32'h80000000);
      check("bp_id", 32'(rsp_id4), 32'd1);
      check("bp_ready_others", 32'(ready4), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready4 = 1'b1;
    @(negedge clk);
    check("bp_handshake_ready", 32'(ready4), 32'd0);
    @(negedge clk);
    check("bp_next_grant", 32'(ready4), 32'b0100);
    @(posedge clk);
    #1;
    valid4[2] = 1'b0;
    exp_ord[0] = 3; exp_ord[1] = 0;
    grant_seq4(2, 1'b1);
    wait_idle4();

    // Reset while requester 3 is in EXEC: its result must never appear.
    op1_4[3] = 32'hFFFF0000; op2_4[3] = 32'h0000FFFF; sel_4[3] = OP_XOR;
    valid4[3] = 1'b1;
    wait_grant4(ok);
    check("mid_grant3", 32'(ready4), 32'b1000);
    @(posedge clk);
    #1;
    valid4[3] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(ready4), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 32'(rsp_valid4), 32'd0);
      check("idle_after_rst", 32'(busy4), 32'd0);
    end
    @(posedge clk);
    #1;
    op1_4[0] = 32'd2; op2_4[0] = 32'd2; sel_4[0] = OP_ADD;
    push_exp(0, 32'd4);
    push_exp(3, 32'hFFFFFFFF);
    valid4 = 4'b1001;
    exp_ord[0] = 0; exp_ord[1] = 3;
    grant_seq4(2, 1'b1);
    wait_idle4();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    // Pointer wrap on the 3-requester instance.
    op1_3[0] = 32'd1;  op2_3[0] = 32'd2;
    op1_3[2] = 32'd10; op2_3[2] = 32'd20;
    valid3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      int         want_id;
      bit         seen;
      logic [2:0] want;
      want_id = (k % 2 == 0) ? 0 : 2;
      want = 3'b001 << want_id;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        seen = (ready3 != 3'b0);
      end
      check("wrap_grant", 32'(ready3), 32'(want));
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        seen = rsp_valid3;
      end
      check("wrap_rsp_id", 32'(rsp_id3), 32'(want_id));
      check("wrap_rsp_data", rsp_data3, (want_id == 0) ? 32'd3 : 32'd30);
    end
    @(posedge clk);
    #1;
    valid3 = 3'b0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 32-bit ALU (op1/op2/aluSel -> aluOut) among NUM_REQ requesters.
- Round-robin arbitration. Each requester uses a valid/ready request channel.
- Operands are registered into the ALU. The result is registered and returned on a single response channel tagged with the requester index.
- Sits between the execution front-ends (e.g. integer and address-generation agents) and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ID_W, 2, width of rsp_id; ID_W = ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  bit i = requester i has a request.
- req_ready  out  NUM_REQ  bit i = request i accepted this cycle; at most one bit set (one-hot).
- req_op1  in  NUM_REQ*32  packed operand 1; requester i uses bits [32*i+31:32*i].
- req_op2  in  NUM_REQ*32  packed operand 2, same packing.
- req_sel  in  NUM_REQ*4  packed aluSel code, same packing (4-bit slices).
- alu_op1  out  32  to ALU op1.
- alu_op2  out  32  to ALU op2.
- alu_sel  out  4  to ALU aluSel.
- alu_out  in  32  from ALU aluOut (combinational).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  ALU result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - alu_op1, alu_op2, alu_sel = 0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - req_ready=0 while rst=1.
  - An in-flight transaction is dropped silently. No response is ever produced for it.
- Grant (combinational, IDLE only):
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 for the winner only; all other bits 0.
  - In EXEC or RESP, req_ready = 0.
- IDLE -> EXEC on any grant. At that edge:
  - alu_op1/op2/sel are loaded from the winner's slice.
  - cur_id is set to i.
  - rr_ptr becomes (i+1) mod NUM_REQ.
  - With no request pending, stay in IDLE with rr_ptr unchanged.
- EXEC -> RESP unconditionally after 1 cycle. At that edge: rsp_data <= alu_out, rsp_id <= cur_id, rsp_valid <= 1.
- RESP:
  - rsp_valid, rsp_data and rsp_id stay stable until the cycle in which rsp_valid & rsp_ready.
  - At that edge: rsp_valid <= 0, state -> IDLE.
  - No new grant is issued in the handshake cycle.
- Latency: request accept edge to rsp_valid high = 2 cycles.
- Throughput: 1 result per 3 cycles with rsp_ready held high.
- ALU drive:
  - alu_* registers hold their last values outside EXEC; they are not cleared.
  - The sel code is passed through unmodified; undefined codes yield whatever the ALU yields.
  - No arithmetic is performed in this block.
- Requester rules:
  - req_valid and the requester's operand slices must stay stable until its req_ready.
  - Dropping req_valid before grant is legal; that request is simply never granted.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - A requester that reasserts valid immediately after its grant waits for all other pending requesters.
  - rsp_ready high in IDLE or EXEC has no effect.
- rsp_id wraps modulo NUM_REQ. NUM_REQ that is not a power of two must never produce an id >= NUM_REQ.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1. Required: req_ready=0, rsp_valid=0, busy=0. After release, the first grant goes to requester 0.
- Single op: requester 2 issues ADD, op1=5, op2=3, rsp_ready=1. Required:
  - req_ready=0b0100 for 1 cycle.
  - rsp_valid high 2 cycles after acceptance with rsp_data=8, rsp_id=2.
  - busy high for 2 cycles.
- Round-robin fairness: all 4 requesters continuously valid, each with SUB, op1=100+i, op2=i. Required: grant order 0,1,2,3,0; each rsp_data=100; successive rsp_valid pulses 3 cycles apart.
- Backpressure: requester 1 issues SLL, op1=1, op2=31; rsp_ready held 0 for 5 cycles. Required:
  - rsp_data=32'h80000000 and rsp_id=1 stable throughout.
  - req_ready=0 for the others.
  - Next grant only in the cycle after the handshake.
- Reset mid-operation: assert rst while in EXEC (requester 3, XOR 0xFFFF0000^0x0000FFFF). Required: no response is ever produced; rr_ptr returns to 0, so requester 0 wins the next contention against requester 3.
- Pointer wrap: NUM_REQ=3, requesters 0 and 2 valid. Required: grants 0,2,0,2; rsp_id never equals 3.
